// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Address width, data width, counter width and arbiter state encodings.
package rf_write_arbiter_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int CNT_W     = 8;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rf_wr_reg.sv
// Registered RegFile write port: address, enable and data.
// Clears to zero on synchronous reset.
module rf_wr_reg
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [RF_ADDR_W-1:0] i_rdst,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_we,
  output logic [RF_ADDR_W-1:0] o_rdst,
  output logic [WIDTH-1:0]     o_data
);

  logic                 r_we;
  logic [RF_ADDR_W-1:0] r_rdst;
  logic [WIDTH-1:0]     r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rdst <= '0;
      r_data <= '0;
    end else begin
      r_we   <= i_we;
      r_rdst <= i_rdst;
      r_data <= i_data;
    end
  end

  assign o_we   = r_we;
  assign o_rdst = r_rdst;
  assign o_data = r_data;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the RegFile write port between writeback and the long-latency
// unit; a starvation counter forces a one-cycle WB stall for the LU.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH        = RF_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_ADDR_W-1:0] i_wb_rdst,
  input  logic                 i_wb_reg_write_rf,
  input  logic [WIDTH-1:0]     i_wb_data,
  input  logic                 i_lu_valid,
  input  logic [RF_ADDR_W-1:0] i_lu_rdst,
  input  logic [WIDTH-1:0]     i_lu_data,
  output logic                 o_lu_ready,
  output logic                 o_stall_wb,
  output logic [RF_ADDR_W-1:0] o_rf_rdst,
  output logic                 o_rf_reg_write_rf,
  output logic [WIDTH-1:0]     o_rf_data
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0] w_wait_inc;

  logic                 w_grant_main;
  logic                 w_grant_lu;
  logic                 w_refused;
  logic                 w_we_nxt;
  logic [RF_ADDR_W-1:0] w_rdst_nxt;
  logic [WIDTH-1:0]     w_data_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_NORMAL;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign w_wait_inc = sat_inc(r_wait_cnt, LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      ARB_NORMAL: begin
        if (w_grant_lu) begin
          w_wait_nxt = '0;
        end else if (w_refused) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == LIM) w_state_nxt = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        w_wait_nxt  = '0;
        w_state_nxt = ARB_NORMAL;
      end
      default: begin
        w_wait_nxt  = '0;
        w_state_nxt = ARB_NORMAL;
      end
    endcase
  end

  always_comb begin
    w_grant_main = 1'b0;
    w_grant_lu   = 1'b0;
    o_stall_wb   = 1'b0;
    unique case (r_state)
      ARB_NORMAL: begin
        w_grant_main = i_wb_reg_write_rf;
        w_grant_lu   = !i_wb_reg_write_rf && i_lu_valid;
      end
      ARB_FORCE: begin
        o_stall_wb = 1'b1;
        w_grant_lu = i_lu_valid;
      end
      default: ;
    endcase
  end

  assign o_lu_ready = w_grant_lu;
  assign w_refused  = i_lu_valid && !w_grant_lu;

  // Idle slots load zeros so stale data never sits on the port.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_rdst_nxt = '0;
    w_data_nxt = '0;
    unique case (1'b1)
      w_grant_main: begin
        w_we_nxt   = 1'b1;
        w_rdst_nxt = i_wb_rdst;
        w_data_nxt = i_wb_data;
      end
      w_grant_lu: begin
        w_we_nxt   = 1'b1;
        w_rdst_nxt = i_lu_rdst;
        w_data_nxt = i_lu_data;
      end
      default: ;
    endcase
  end

  rf_wr_reg #(
    .WIDTH(WIDTH)
  ) u_rf_wr_reg (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we_nxt),
    .i_rdst (w_rdst_nxt),
    .i_data (w_data_nxt),
    .o_we   (o_rf_reg_write_rf),
    .o_rdst (o_rf_rdst),
    .o_data (o_rf_data)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed steps push expected
// writes, a monitor pops and compares each registered write.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  i_wb_rdst;
  logic        i_wb_reg_write_rf;
  logic [31:0] i_wb_data;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rdst;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        o_stall_wb;
  logic [4:0]  o_rf_rdst;
  logic        o_rf_reg_write_rf;
  logic [31:0] o_rf_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rf_write_arbiter #(
    .WIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_wb_rdst         (i_wb_rdst),
    .i_wb_reg_write_rf (i_wb_reg_write_rf),
    .i_wb_data         (i_wb_data),
    .i_lu_valid        (i_lu_valid),
    .i_lu_rdst         (i_lu_rdst),
    .i_lu_data         (i_lu_data),
    .o_lu_ready        (o_lu_ready),
    .o_stall_wb        (o_stall_wb),
    .o_rf_rdst         (o_rf_rdst),
    .o_rf_reg_write_rf (o_rf_reg_write_rf),
    .o_rf_data         (o_rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: registered outputs, sampled 1 unit after each posedge.
  always @(posedge clk) begin
    logic rs;
    wr_t  e;
    rs = rst;
    #1;
    if (rs) begin
      chk("rst_we", 64'(o_rf_reg_write_rf), 64'd0);
      chk("rst_rdst", 64'(o_rf_rdst), 64'd0);
      chk("rst_data", 64'(o_rf_data), 64'd0);
      chk("rst_stall", 64'(o_stall_wb), 64'd0);
    end else if (o_rf_reg_write_rf) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(o_rf_rdst), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rdst", 64'(o_rf_rdst), 64'(e.rd));
        chk("wr_data", 64'(o_rf_data), 64'(e.d));
      end
    end
  end

  // push: -1 no comb check, 0 no write expected, 1 main, 2 LU
  task automatic step(
    input string nm, input logic r,
    input logic we, input logic [4:0] wrd, input logic [31:0] wd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic er, input logic es, input int push
  );
    wr_t w;
    @(negedge clk);
    rst = r;
    i_wb_reg_write_rf = we;
    i_wb_rdst = wrd;
    i_wb_data = wd;
    i_lu_valid = lv;
    i_lu_rdst = lrd;
    i_lu_data = ld;
    #1;
    if (push >= 0) begin
      chk({nm, "_ready"}, 64'(o_lu_ready), 64'(er));
      chk({nm, "_stall"}, 64'(o_stall_wb), 64'(es));
    end
    if (push == 1) begin
      w.rd = wrd; w.d = wd; exp_q.push_back(w);
    end else if (push == 2) begin
      w.rd = lrd; w.d = ld; exp_q.push_back(w);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_wb_reg_write_rf = 1'b1;
    i_wb_rdst = 5'd1;
    i_wb_data = 32'h1111;
    i_lu_valid = 1'b1;
    i_lu_rdst = 5'd2;
    i_lu_data = 32'h2222;

    step("rst0", 1, 1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222, 0, 0, -1);
    step("rst1", 1, 1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222, 0, 0, 0);
    step("main", 0, 1, 5'd3, 32'hDEADBEEF, 1, 5'd7, 32'h12345678, 0, 0, 1);
    step("idle_lu", 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678, 1, 0, 2);
    step("idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 4; i++)
      step("starve", 0, 1, 5'd5, 32'h55, 1, 5'd9, 32'h99, 0, 0, 1);
    step("force", 0, 1, 5'd5, 32'h55, 1, 5'd9, 32'h99, 1, 1, 2);
    step("held", 0, 1, 5'd5, 32'h55, 0, 5'd0, 32'h0, 0, 0, 1);

    step("coll", 0, 1, 5'd4, 32'h1, 1, 5'd4, 32'h2, 0, 0, 1);
    step("coll_lu", 0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h2, 1, 0, 2);
    step("rd0", 0, 1, 5'd0, 32'hCAFE, 0, 5'd0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 4; i++)
      step("starve2", 0, 1, 5'd6, 32'h66, 1, 5'd10, 32'hAA, 0, 0, 1);
    step("rst_force", 1, 1, 5'd6, 32'h66, 1, 5'd10, 32'hAA, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      step("post_rst", 0, 1, 5'd6, 32'h66, 1, 5'd10, 32'hAA, 0, 0, 1);
    step("force2", 0, 1, 5'd6, 32'h66, 1, 5'd10, 32'hAA, 1, 1, 2);
    step("held2", 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 0, 1);
    step("drain0", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    step("drain1", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two sources.
  - The in-order pipeline writeback stage (main).
  - The multi-cycle long-latency unit, LU (mul/div/load-miss return).
- Main has priority. LU is served in idle write slots.
- A starvation counter forces a one-cycle pipeline stall so LU can retire.
- Output is registered: one cycle of latency, feeding the RegFile write port and the virtual-writeback forwarding path.

Parameters:
- WIDTH, 32, data width of the register file.
- STARVE_LIMIT, 4, number of consecutive refused LU-valid cycles before a forced grant; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_wb_rdst  in  5  main destination register
- i_wb_reg_write_rf  in  1  main write request
- i_wb_data  in  WIDTH  main write data
- i_lu_valid  in  1  LU result valid; held until accepted
- i_lu_rdst  in  5  LU destination register
- i_lu_data  in  WIDTH  LU write data
- o_lu_ready  out  1  LU result accepted this cycle (combinational)
- o_stall_wb  out  1  main pipeline must hold WB stage and its inputs (combinational from state)
- o_rf_rdst  out  5  registered RegFile write address
- o_rf_reg_write_rf  out  1  registered RegFile write enable
- o_rf_data  out  WIDTH  registered RegFile write data

Behaviour:
- Reset (rst=1 at posedge):
  - o_rf_rdst=0, o_rf_reg_write_rf=0, o_rf_data=0.
  - state=NORMAL, wait_cnt=0.
  - Combinational outputs therefore reset to o_stall_wb=0; o_lu_ready=0 while in NORMAL with i_wb_reg_write_rf=1, or with i_lu_valid=0.
  - Reset mid-operation: any pending LU grant is abandoned. LU keeps i_lu_valid high and is served after reset.
- States: NORMAL, FORCE.
- NORMAL:
  - i_wb_reg_write_rf=1: grant main; o_lu_ready=0.
  - Else if i_lu_valid=1: grant LU; o_lu_ready=1.
  - Else: no grant; next o_rf_reg_write_rf=0. o_rf_rdst and o_rf_data load 0.
- FORCE:
  - o_stall_wb=1; main inputs ignored.
  - If i_lu_valid=1: grant LU, o_lu_ready=1.
  - If i_lu_valid=0 (protocol violation): no write.
  - Always returns to NORMAL next cycle.
- Grant effect: at the next posedge o_rf_* load the granted source's rdst and data, with o_rf_reg_write_rf=1. Latency is exactly 1 cycle.
- wait_cnt:
  - In NORMAL, increments when i_lu_valid=1 and o_lu_ready=0.
  - Clears on any LU accept, and in FORCE.
  - Saturates at STARVE_LIMIT.
- Transition NORMAL→FORCE: at a posedge where the incremented wait_cnt equals STARVE_LIMIT. With STARVE_LIMIT=N, FORCE is entered after N consecutive refused cycles.
- The stalled main request is held by the pipeline and is granted in the cycle after FORCE. No main write is lost or duplicated.
- Same rdst from both sources in one cycle: main wins; LU waits. WAW ordering is the hazard unit's responsibility.
- rdst=0 is passed through unchanged; RegFile handles r0.
- Width of wait_cnt: 8 bits.

Decomposition:
- Shared package pipelinedefs.vh gets:
  - WIDTH
  - RF_ADDR_W=5
  - State encodings ARB_NORMAL=1'b0, ARB_FORCE=1'b1
- Natural sub-module: rf_wr_reg, the reset-to-zero output register triple (rdst, write enable, data).
- The arbiter keeps the FSM, counter and mux.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs active -> all o_rf_*=0, o_stall_wb=0. First post-reset cycle with main write and LU valid gives o_lu_ready=0.
- Main only: wb(rdst=3, data=0xDEADBEEF, we=1) -> next cycle o_rf_rdst=3, o_rf_data=0xDEADBEEF, we=1; o_lu_ready=0.
- Idle slot: wb we=0, lu_valid=1 (rdst=7, data=0x12345678) -> o_lu_ready=1 same cycle; next cycle o_rf = 7/0x12345678/1.
- Starvation (STARVE_LIMIT=4): main we=1 every cycle (rdst=5), lu_valid=1 (rdst=9) ->
  - o_lu_ready=0 for 4 cycles.
  - 5th cycle: o_stall_wb=1, o_lu_ready=1.
  - Next cycle: o_rf_rdst=9, o_stall_wb=0.
  - Held main rdst=5 written the cycle after.
- Collision: both request rdst=4, main data=1, LU data=2 -> o_rf_data=1 first; LU's 2 written in the first idle slot or forced slot.
- Reset in FORCE: assert rst while o_stall_wb=1 -> next cycle o_stall_wb=0, wait_cnt=0, o_rf_reg_write_rf=0.
